kronos_fetch_unit: RTL and testbench
====================================

Name: kronos_fetch_unit

Overview:
- IF stage of the Kronos RV32I core. It masters the instruction bus and produces the IF/ID stream (fetch, fetch_vld) consumed by decode under a valid/ready handshake.
- It holds the PC, keeps at most one bus request outstanding, and buffers returned instructions in a 2-entry FIFO.
- On a redirect (jump, taken branch, trap, fence.i) it discards stale instructions and refetches from the redirect target.

Parameters:
BOOT_ADDR, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
instr_addr  out  32  instruction bus address, word aligned
instr_req  out  1  bus request; held with stable addr until instr_ack
instr_data  in  32  read data, valid when instr_ack
instr_ack  in  1  bus acknowledge; may be asserted in the same cycle as instr_req
fetch  out  pipeIFID_t  .pc / .ir of the FIFO head
fetch_vld  out  1  FIFO non-empty
fetch_rdy  in  1  decode accepts head; pop = fetch_vld & fetch_rdy
redirect  in  1  one-cycle pulse: flush and restart at redirect_target
redirect_target  in  32  new PC; bits [1:0] are ignored and treated as 0

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: pc=BOOT_ADDR, state=IDLE, FIFO count=0, instr_req=0, instr_addr=BOOT_ADDR, fetch_vld=0, fetch=0.
- State register: {IDLE, REQ, DISCARD}. instr_req=1 in REQ and DISCARD. instr_addr=pc.
- FIFO: 2 entries of {pc, ir}, registered.
  - push = instr_ack in REQ with no redirect.
  - Push and pop in the same cycle are allowed.
  - Push when full cannot occur (guaranteed by the issue rule); an assertion flags it.
- Occupancy: occ_next = count + push - pop.
- IDLE:
  - redirect -> pc=target, FIFO cleared, go REQ.
  - else if occ_next < 2 -> REQ.
  - else stay IDLE.
- REQ:
  - redirect (with or without ack) -> pc=target, FIFO cleared. The same-cycle ack data is dropped. Go REQ if ack, else DISCARD.
  - ack without redirect -> push {pc, instr_data}, pc=pc+4. Go REQ if occ_next < 2, else IDLE.
  - no ack -> hold pc and stay in REQ.
- DISCARD (the bus cannot abort an in-flight request):
  - Keeps requesting the old address.
  - ack -> data dropped, go REQ at the current pc.
  - A new redirect updates pc; the request in flight still completes and is discarded.
- Redirect priority:
  - redirect beats a same-cycle pop and push.
  - fetch_vld=0 in the cycle after a redirect.
  - No instruction fetched before the redirect is ever presented after it.
- Latency and throughput:
  - ack in cycle N -> entry visible on fetch/fetch_vld in cycle N+1.
  - With zero-wait ack and fetch_rdy=1, one instruction per cycle is sustained.
  - After reset release, the first req is at BOOT_ADDR in the cycle following release.
- Output stability: fetch and fetch_vld are stable while fetch_vld=1 and fetch_rdy=0.
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Reset mid-transaction: rst asserted while instr_req=1 drops instr_req immediately. Any ack after release is ignored unless the unit is in REQ.

Test Plan:
- Reset release, zero-wait memory (mem[a]=a^32'hA5A5_0000), fetch_rdy=1 -> fetch.pc=0,4,8,... on consecutive cycles, first fetch_vld 2 cycles after release, .ir matching mem.
- fetch_rdy=0 for 10 cycles -> FIFO fills with pc 0 and 4, instr_req drops (state IDLE) and no addr 8 is requested. fetch_rdy=1 -> fetch.pc 0, 4, 8 in order with no duplicates or gaps.
- Memory with 3-cycle ack latency; redirect to 0x100 one cycle into a request for 0x8 -> request for 0x8 completes and is dropped, next req addr=0x100, first fetch.pc=0x100.
- redirect to 0x200 in the same cycle as ack and pop with FIFO holding 2 entries -> fetch_vld=0 next cycle, next req addr=0x200, then fetch.pc=0x200.
- redirect_target=0x0000_0103 -> fetch from 0x100. PC at 0xFFFF_FFFC -> next request addr 0x0000_0000.
- Assert rst while instr_req=1 with ack pending; release -> instr_req=0 during reset, restart at BOOT_ADDR, fetch_vld=0 until the new ack.

Source files
------------

// File: rtl/kronos_fetch_unit.sv
// -----------------------------------------------------------------------------
// kronos_fetch_unit
//
// Instruction-fetch stage of the Kronos RV32I core. It masters the instruction
// bus with at most one request in flight, buffers returned words in a 2-entry
// FIFO and presents the head to decode as the IF/ID stream. A redirect flushes
// the FIFO and restarts fetching at the (word-aligned) redirect target; a
// request already on the bus is allowed to finish and its data is thrown away.
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   instr_addr        bus address (word aligned), stable while instr_req=1
//   instr_req         bus request, held until instr_ack
//   instr_data        bus read data, valid with instr_ack
//   instr_ack         bus acknowledge (may coincide with the request cycle)
//   fetch             head of the FIFO: {pc, ir}
//   fetch_vld         FIFO not empty
//   fetch_rdy         decode takes the head this cycle
//   redirect          one-cycle flush/restart pulse
//   redirect_target   restart address, bits [1:0] ignored
// -----------------------------------------------------------------------------

package kronos_fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;
endpackage

module kronos_fetch_unit
    import kronos_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
    output pipeIFID_t   fetch,
    output logic        fetch_vld,
    input  logic        fetch_rdy,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] addr_next;
    logic [31:0] target;

    pipeIFID_t   head;
    pipeIFID_t   tail;
    pipeIFID_t   entry_in;
    logic [1:0]  count;
    logic [1:0]  occ_next;
    logic        push;
    logic        pop;
    logic        room;

    assign fetch     = head;
    assign fetch_vld = (count != 2'd0);

    always_comb begin
        target     = redirect_target & 32'hFFFF_FFFC;
        push       = (state == REQ) && instr_ack && !redirect;
        pop        = fetch_vld && fetch_rdy;
        occ_next   = count + {1'b0, push} - {1'b0, pop};
        // Only issue a new request when its data is sure to fit.
        room       = (occ_next < 2'd2);
        entry_in.pc = pc;
        entry_in.ir = instr_data;
        state_next = state;
        pc_next    = pc;

        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = REQ;
                end else if (room) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_next    = target;
                    // Without an ack the old request is still on the bus.
                    state_next = instr_ack ? REQ : DISCARD;
                end else if (instr_ack) begin
                    pc_next    = pc + 32'd4;
                    state_next = room ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_next = target;
                end
                if (instr_ack) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        // The bus cannot abort, so a discarded request keeps its old address.
        addr_next = (state_next == DISCARD) ? instr_addr : pc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= BOOT_ADDR;
            instr_addr <= BOOT_ADDR;
            instr_req  <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= 2'd0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr_addr <= addr_next;
            instr_req  <= (state_next != IDLE);

            // Redirect wins over any same-cycle push or pop.
            if (redirect) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) head <= entry_in;
                        else               tail <= entry_in;
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head  <= tail;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            head <= entry_in;
                        end else begin
                            head <= tail;
                            tail <= entry_in;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        push |-> (count != 2'd2));
`endif

endmodule

// File: tb/tb_kronos_fetch_unit.sv
module tb_kronos_fetch_unit;
    import kronos_fetch_pkg::*;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data = '0;
    logic        instr_ack = 1'b0;
    pipeIFID_t   fetch;
    logic        fetch_vld;
    logic        fetch_rdy = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // memory responder controls
    int fixed_lat = 0;
    bit rand_lat  = 0;
    bit stray     = 0;
    int wcnt      = 0;
    int cur_lat   = 0;

    kronos_fetch_unit #(.BOOT_ADDR(BOOT)) dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(instr_data), .instr_ack(instr_ack),
        .fetch(fetch), .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy),
        .redirect(redirect), .redirect_target(redirect_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory: acks a request after cur_lat wait cycles.
    always begin
        @(posedge clk);
        #1;
        if (stray) begin
            instr_ack  = 1'b1;
            instr_data = 32'hDEAD_BEEF;
            stray      = 0;
        end else if (!instr_req) begin
            instr_ack = 1'b0;
            wcnt      = 0;
            cur_lat   = rand_lat ? int'($urandom_range(0, 2)) : fixed_lat;
        end else if (wcnt >= cur_lat) begin
            instr_ack  = 1'b1;
            instr_data = mem_word(instr_addr);
            wcnt       = 0;
            cur_lat    = rand_lat ? int'($urandom_range(0, 2)) : fixed_lat;
        end else begin
            instr_ack = 1'b0;
            wcnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Holds reset for a few cycles, returns at the negedge where rst drops.
    task automatic do_reset(input int lat, input logic rdy);
        @(negedge clk);
        rst       = 1'b1;
        redirect  = 1'b0;
        fetch_rdy = rdy;
        fixed_lat = lat;
        rand_lat  = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (instr_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", instr_req); end
        n_checks++;
        if (instr_addr !== BOOT) begin n_fail++; $display("FAIL reset_addr: got %h want %h", instr_addr, BOOT); end
        n_checks++;
        if (fetch_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", fetch_vld); end
        n_checks++;
        if (fetch !== '0) begin n_fail++; $display("FAIL reset_fetch: got %h want 0", fetch); end
    endtask

    task automatic test_stream();
        do_reset(0, 1'b1);
        n_checks++;
        if (instr_req !== 1'b0) begin n_fail++; $display("FAIL stream_req0: got %b want 0", instr_req); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (instr_req !== 1'b1 || instr_addr !== BOOT) begin
                    n_fail++; $display("FAIL stream_first_req: req %b addr %h want 1 %h", instr_req, instr_addr, BOOT);
                end
                n_checks++;
                if (fetch_vld !== 1'b0) begin n_fail++; $display("FAIL stream_vld_early: got %b want 0", fetch_vld); end
            end else begin
                n_checks++;
                if (fetch_vld !== 1'b1 || fetch.pc !== 32'(4 * (k - 2)) || fetch.ir !== mem_word(32'(4 * (k - 2)))) begin
                    n_fail++;
                    $display("FAIL stream_k%0d: vld %b pc %h ir %h want 1 %h %h", k, fetch_vld, fetch.pc, fetch.ir,
                             32'(4 * (k - 2)), mem_word(32'(4 * (k - 2))));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit saw_hi = 0;
        int acks = 0;
        int got = 0;
        logic [31:0] exp = 32'h0;
        do_reset(0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (instr_req && instr_addr >= 32'h8) saw_hi = 1;
            if (instr_req && instr_ack) acks++;
        end
        n_checks++;
        if (saw_hi !== 1'b0) begin n_fail++; $display("FAIL bp_no_addr8: got %b want 0", saw_hi); end
        n_checks++;
        if (acks != 2) begin n_fail++; $display("FAIL bp_acks: got %0d want 2", acks); end
        n_checks++;
        if (instr_req !== 1'b0) begin n_fail++; $display("FAIL bp_idle_req: got %b want 0", instr_req); end
        n_checks++;
        if (fetch_vld !== 1'b1 || fetch.pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_head: vld %b pc %h want 1 0", fetch_vld, fetch.pc);
        end
        fetch_rdy = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (fetch_vld && fetch_rdy) begin
                n_checks++;
                if (fetch.pc !== exp || fetch.ir !== mem_word(exp)) begin
                    n_fail++; $display("FAIL bp_order: pc %h ir %h want %h %h", fetch.pc, fetch.ir, exp, mem_word(exp));
                end
                exp += 32'd4;
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 6) begin n_fail++; $display("FAIL bp_timeout: got %0d pops want 6", got); end
    endtask

    task automatic test_redirect_inflight();
        bit found = 0;
        bit bad = 0;
        do_reset(3, 1'b1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (instr_req && instr_addr == 32'h8) begin found = 1; break; end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rif_wait8: no request for 8 seen, want one"); end
        redirect = 1'b1;
        redirect_target = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if (fetch_vld !== 1'b0) begin n_fail++; $display("FAIL rif_vld_after: got %b want 0", fetch_vld); end
        n_checks++;
        if (instr_req !== 1'b1 || instr_addr !== 32'h8) begin
            n_fail++; $display("FAIL rif_hold8: req %b addr %h want 1 8", instr_req, instr_addr);
        end
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fetch_vld) bad = 1;
            if (instr_req && instr_addr != 32'h8) begin found = 1; break; end
        end
        n_checks++;
        if (!found || instr_addr !== 32'h100) begin
            n_fail++; $display("FAIL rif_next_addr: found %b addr %h want 1 100", found, instr_addr);
        end
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (fetch_vld) begin found = 1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (bad || !found || fetch.pc !== 32'h100 || fetch.ir !== mem_word(32'h100)) begin
            n_fail++; $display("FAIL rif_first_fetch: stale %b found %b pc %h ir %h want 0 1 100 %h",
                               bad, found, fetch.pc, fetch.ir, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_full();
        bit found = 0;
        do_reset(0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!instr_req && fetch_vld) begin found = 1; break; end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rfull_fill: FIFO never filled, want full"); end
        stray = 1;          // ack arrives while the unit is idle and full
        @(negedge clk);
        fetch_rdy = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if (fetch_vld !== 1'b0) begin n_fail++; $display("FAIL rfull_vld: got %b want 0", fetch_vld); end
        n_checks++;
        if (instr_req !== 1'b1 || instr_addr !== 32'h200) begin
            n_fail++; $display("FAIL rfull_addr: req %b addr %h want 1 200", instr_req, instr_addr);
        end
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fetch_vld) begin found = 1; break; end
        end
        n_checks++;
        if (!found || fetch.pc !== 32'h200 || fetch.ir !== mem_word(32'h200)) begin
            n_fail++; $display("FAIL rfull_first: found %b pc %h ir %h want 1 200 %h", found, fetch.pc, fetch.ir, mem_word(32'h200));
        end
        // Streaming case: redirect together with ack, push and pop.
        repeat (3) @(negedge clk);
        n_checks++;
        if (!(fetch_vld && instr_req && instr_ack)) begin
            n_fail++; $display("FAIL rstream_setup: vld %b req %b ack %b want 1 1 1", fetch_vld, instr_req, instr_ack);
        end
        redirect = 1'b1;
        redirect_target = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if (fetch_vld !== 1'b0 || instr_addr !== 32'h300) begin
            n_fail++; $display("FAIL rstream_after: vld %b addr %h want 0 300", fetch_vld, instr_addr);
        end
        @(negedge clk);
        n_checks++;
        if (fetch_vld !== 1'b1 || fetch.pc !== 32'h300) begin
            n_fail++; $display("FAIL rstream_first: vld %b pc %h want 1 300", fetch_vld, fetch.pc);
        end
    endtask

    task automatic test_align_wrap();
        logic [31:0] exp;
        int got = 0;
        do_reset(0, 1'b1);
        repeat (3) @(negedge clk);
        redirect = 1'b1;
        redirect_target = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if (instr_addr !== 32'h100) begin n_fail++; $display("FAIL align_addr: got %h want 100", instr_addr); end
        @(negedge clk);
        n_checks++;
        if (fetch_vld !== 1'b1 || fetch.pc !== 32'h100) begin
            n_fail++; $display("FAIL align_fetch: vld %b pc %h want 1 100", fetch_vld, fetch.pc);
        end
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if (instr_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", instr_addr); end
        exp = 32'hFFFF_FFFC;
        @(negedge clk);
        n_checks++;
        if (instr_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 0", instr_addr); end
        for (int c = 0; c < 10 && got < 3; c++) begin
            if (fetch_vld && fetch_rdy) begin
                n_checks++;
                if (fetch.pc !== exp || fetch.ir !== mem_word(exp)) begin
                    n_fail++; $display("FAIL wrap_fetch: pc %h ir %h want %h %h", fetch.pc, fetch.ir, exp, mem_word(exp));
                end
                exp += 32'd4;
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 3) begin n_fail++; $display("FAIL wrap_timeout: got %0d pops want 3", got); end
    endtask

    task automatic test_reset_midtx();
        bit found = 0;
        do_reset(3, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (instr_req && !instr_ack) begin found = 1; break; end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rmid_wait: no pending request seen, want one"); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (instr_req !== 1'b0 || fetch_vld !== 1'b0) begin
            n_fail++; $display("FAIL rmid_drop: req %b vld %b want 0 0", instr_req, fetch_vld);
        end
        @(negedge clk);
        stray = 1;          // ack lands in the first idle cycle after release
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (instr_req !== 1'b0 || fetch_vld !== 1'b0) begin
            n_fail++; $display("FAIL rmid_release: req %b vld %b want 0 0", instr_req, fetch_vld);
        end
        @(negedge clk);
        n_checks++;
        if (instr_req !== 1'b1 || instr_addr !== BOOT || fetch_vld !== 1'b0) begin
            n_fail++; $display("FAIL rmid_restart: req %b addr %h vld %b want 1 %h 0", instr_req, instr_addr, fetch_vld, BOOT);
        end
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fetch_vld) begin found = 1; break; end
        end
        n_checks++;
        if (!found || fetch.pc !== BOOT || fetch.ir !== mem_word(BOOT)) begin
            n_fail++; $display("FAIL rmid_first: found %b pc %h ir %h want 1 %h %h", found, fetch.pc, fetch.ir, BOOT, mem_word(BOOT));
        end
    endtask

    // Randomized traffic against an in-order program-stream model.
    task automatic test_random();
        logic [31:0] exp_pc = BOOT;
        logic [31:0] prev_addr = '0;
        pipeIFID_t   prev_fetch = '0;
        bit prev_redir = 0, prev_hold = 0, prev_pend = 0;
        int pops = 0;
        do_reset(0, 1'b1);
        rand_lat = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (prev_redir) begin
                n_checks++;
                if (fetch_vld !== 1'b0) begin n_fail++; $display("FAIL rnd_flush c%0d: vld %b want 0", c, fetch_vld); end
            end
            if (prev_hold) begin
                n_checks++;
                if (fetch_vld !== 1'b1 || fetch !== prev_fetch) begin
                    n_fail++; $display("FAIL rnd_stable c%0d: vld %b fetch %h want 1 %h", c, fetch_vld, fetch, prev_fetch);
                end
            end
            if (prev_pend) begin
                n_checks++;
                if (instr_req !== 1'b1 || instr_addr !== prev_addr) begin
                    n_fail++; $display("FAIL rnd_bus_hold c%0d: req %b addr %h want 1 %h", c, instr_req, instr_addr, prev_addr);
                end
            end
            fetch_rdy = ($urandom_range(0, 3) != 0);
            redirect  = ($urandom_range(0, 19) == 0);
            if (redirect) begin
                redirect_target = $urandom();
                if ($urandom_range(0, 3) == 0) redirect_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end
            if (fetch_vld && fetch_rdy) begin
                n_checks++;
                if (fetch.pc !== exp_pc || fetch.ir !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_stream c%0d: pc %h ir %h want %h %h", c, fetch.pc, fetch.ir, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
                pops++;
            end
            if (redirect) exp_pc = redirect_target & 32'hFFFF_FFFC;
            prev_redir = redirect;
            prev_hold  = fetch_vld && !fetch_rdy && !redirect;
            prev_fetch = fetch;
            prev_pend  = instr_req && !instr_ack;
            prev_addr  = instr_addr;
        end
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if (pops < 300) begin n_fail++; $display("FAIL rnd_progress: got %0d pops want >= 300", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_full();
        test_align_wrap();
        test_reset_midtx();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
